// File: rtl/ccd_line_axis.sv
`default_nettype none
// ============================================================================
// Module   : ccd_line_axis
// Purpose  : Frames CCD pixel strobes into fixed-length lines and sends them
//            out on an AXI4-Stream master through a first-word-fall-through
//            FIFO. Short lines are zero-padded, and the line's last beat is
//            always delivered. Sticky ovf and line_err flags report faults.
// Options  : Defining CCD_LINE_DARK_SUB_EN adds saturating dark-level
//            subtraction and one input register stage.
// Revision : 1.0 - initial release
// ============================================================================

module ccd_line_axis #(
    parameter int D_WIDTH         = 8,
    parameter int SAMP_NUM        = 2048,
    parameter int LINES_PER_FRAME = 1024,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic               sys_clk,
    input  logic               resetn,
    input  logic               sh,
    input  logic [D_WIDTH-1:0] s_tdata,
    input  logic               s_tvalid,
    input  logic [D_WIDTH-1:0] dark_level,
    input  logic               clr_err,
    output logic [D_WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic               ovf,
    output logic               line_err
);

    localparam int PC_W = $clog2(SAMP_NUM + 1);
    localparam int LC_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW   = D_WIDTH + 2;

    localparam logic [PC_W-1:0] c_last_pix  = PC_W'(SAMP_NUM - 1);
    localparam logic [LC_W-1:0] c_last_line = LC_W'(LINES_PER_FRAME - 1);
    localparam logic [AW:0]     c_full_cnt  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        ACTIVE    = 3'd2,
        PAD       = 3'd3,
        LAST_WAIT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input stage: pixel and sh travel together so line framing is the
    // same with or without the extra subtraction register.
    // ------------------------------------------------------------------
    logic               w_sh;
    logic               w_pix_vld;
    logic [D_WIDTH-1:0] w_pix_data;

`ifdef CCD_LINE_DARK_SUB_EN
    logic               r_stg_sh;
    logic               r_stg_vld;
    logic [D_WIDTH-1:0] r_stg_data;

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_stg_sh   <= 1'b0;
            r_stg_vld  <= 1'b0;
            r_stg_data <= '0;
        end else begin
            r_stg_sh   <= sh;
            r_stg_vld  <= s_tvalid;
            r_stg_data <= (s_tdata > dark_level) ? (s_tdata - dark_level) : '0;
        end
    end

    assign w_sh       = r_stg_sh;
    assign w_pix_vld  = r_stg_vld;
    assign w_pix_data = r_stg_data;
`else
    logic w_unused_dark;

    assign w_unused_dark = ^dark_level;
    assign w_sh          = sh;
    assign w_pix_vld     = s_tvalid;
    assign w_pix_data    = s_tdata;
`endif

    // ------------------------------------------------------------------
    // Output FIFO storage and occupancy
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_space;
    logic [EW-1:0] w_head;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && m_axis_tready;
    // A pop in the same cycle frees the slot a full FIFO would refuse.
    assign w_space = !w_full || w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sh_q;
    logic [PC_W-1:0] r_pix_cnt;
    logic [PC_W-1:0] w_pix_cnt_nxt;
    logic [LC_W-1:0] r_line_cnt;
    logic [LC_W-1:0] w_line_cnt_nxt;
    logic [LC_W-1:0] w_line_inc;
    logic [EW-1:0]   r_pend;
    logic [EW-1:0]   w_pend_nxt;
    logic            r_ovf;
    logic            r_line_err;

    logic            w_sh_rise;
    logic            w_is_last;
    logic            w_first_of_frame;
    logic [EW-1:0]   w_pix_entry;
    logic            w_push;
    logic [EW-1:0]   w_push_entry;
    logic            w_ovf_set;
    logic            w_err_set;

    assign w_sh_rise        = w_sh && !r_sh_q;
    assign w_is_last        = (r_pix_cnt == c_last_pix);
    assign w_first_of_frame = (r_pix_cnt == '0) && (r_line_cnt == '0);
    assign w_pix_entry      = {w_first_of_frame, w_is_last, w_pix_data};
    assign w_line_inc       = (r_line_cnt == c_last_line) ? '0 : (r_line_cnt + 1'b1);

    always_comb begin
        w_state_nxt    = r_state;
        w_pix_cnt_nxt  = r_pix_cnt;
        w_line_cnt_nxt = r_line_cnt;
        w_pend_nxt     = r_pend;
        w_push         = 1'b0;
        w_push_entry   = '0;
        w_ovf_set      = 1'b0;
        w_err_set      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_sh_rise) begin
                    w_state_nxt = ARMED;
                end
            end

            ARMED, ACTIVE: begin
                if ((r_state == ACTIVE) && w_sh_rise) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = PAD;
                end else if (w_pix_vld) begin
                    w_state_nxt = ACTIVE;
                    if (w_space) begin
                        w_push       = 1'b1;
                        w_push_entry = w_pix_entry;
                    end else if (!w_is_last) begin
                        w_ovf_set = 1'b1;
                    end
                    if (w_is_last) begin
                        w_pix_cnt_nxt = '0;
                        if (w_space) begin
                            w_state_nxt    = IDLE;
                            w_line_cnt_nxt = w_line_inc;
                        end else begin
                            // Park the tlast beat rather than lose it.
                            w_pend_nxt  = w_pix_entry;
                            w_state_nxt = LAST_WAIT;
                        end
                    end else begin
                        w_pix_cnt_nxt = r_pix_cnt + 1'b1;
                    end
                end
            end

            PAD: begin
                if (w_space) begin
                    w_push       = 1'b1;
                    w_push_entry = {1'b0, w_is_last, {D_WIDTH{1'b0}}};
                    if (w_is_last) begin
                        // The sh that cut the line short already opened the next one.
                        w_pix_cnt_nxt  = '0;
                        w_line_cnt_nxt = w_line_inc;
                        w_state_nxt    = ARMED;
                    end else begin
                        w_pix_cnt_nxt = r_pix_cnt + 1'b1;
                    end
                end
            end

            LAST_WAIT: begin
                if (w_sh_rise) begin
                    w_err_set = 1'b1;
                end
                if (w_space) begin
                    w_push         = 1'b1;
                    w_push_entry   = r_pend;
                    w_line_cnt_nxt = w_line_inc;
                    w_state_nxt    = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_sh_q     <= 1'b0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_pend     <= '0;
            r_ovf      <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sh_q     <= w_sh;
            r_pix_cnt  <= w_pix_cnt_nxt;
            r_line_cnt <= w_line_cnt_nxt;
            r_pend     <= w_pend_nxt;
            r_ovf      <= w_ovf_set | (r_ovf & ~clr_err);
            r_line_err <= w_err_set | (r_line_err & ~clr_err);
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer and count update
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_empty ? '0 : w_head[D_WIDTH-1:0];
    assign m_axis_tlast  = !w_empty && w_head[D_WIDTH];
    assign m_axis_tuser  = !w_empty && w_head[D_WIDTH+1];
    assign ovf           = r_ovf;
    assign line_err      = r_line_err;

endmodule

`default_nettype wire

// File: tb/tb_ccd_line_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccd_line_axis
// Purpose  : Directed self-checking bench for ccd_line_axis (SAMP_NUM=8,
//            LINES_PER_FRAME=2, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================

module tb_ccd_line_axis;

    localparam int DW = 8;
`ifdef CCD_LINE_DARK_SUB_EN
    localparam int            LAT      = 2;
    localparam logic [DW-1:0] DARK_DEF = 8'd0;
`else
    localparam int            LAT      = 1;
    localparam logic [DW-1:0] DARK_DEF = 8'hA5;
`endif

    logic          sys_clk       = 1'b0;
    logic          resetn        = 1'b0;
    logic          sh            = 1'b0;
    logic [DW-1:0] s_tdata       = '0;
    logic          s_tvalid      = 1'b0;
    logic [DW-1:0] dark_level    = DARK_DEF;
    logic          clr_err       = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          ovf;
    logic          line_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] got [$];

    always #5 sys_clk = ~sys_clk;

    ccd_line_axis #(
        .D_WIDTH        (DW),
        .SAMP_NUM       (8),
        .LINES_PER_FRAME(2),
        .FIFO_DEPTH     (4)
    ) dut (
        .sys_clk      (sys_clk),
        .resetn       (resetn),
        .sh           (sh),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .dark_level   (dark_level),
        .clr_err      (clr_err),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .ovf          (ovf),
        .line_err     (line_err)
    );

    // Inputs are stable from posedge+1 onward, so a negedge handshake means a pop.
    always @(negedge sys_clk) begin
        if (resetn && m_axis_tvalid && m_axis_tready)
            got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    end

    function automatic logic [9:0] beat(input logic u, input logic l, input logic [7:0] d);
        return {u, l, d};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_sh();
        sh = 1'b1;
        tick();
        sh = 1'b0;
        tick();
    endtask

    task automatic send_pix(input logic [7:0] v);
        s_tvalid = 1'b1;
        s_tdata  = v;
        tick();
        s_tvalid = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ovf, line_err} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b u=%b ovf=%b err=%b, want all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ovf, line_err);
        end
        resetn = 1'b1;
        tick();
        s_tvalid = 1'b1;
        s_tdata  = 8'h77;
        repeat (3) tick();
        s_tvalid = 1'b0;
        tick();
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignores_pixels: got tvalid=%b want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_basic_lines();
        logic [9:0] exp [$];
        int base = got.size();
        m_axis_tready = 1'b1;
        for (int ln = 0; ln < 3; ln++) begin
            pulse_sh();
            send_pix(8'(ln * 10 + 1));
            if (ln == 0) begin
                for (int k = 1; k <= LAT; k++) begin
                    n_cmp++;
                    if (m_axis_tvalid !== (k == LAT)) begin
                        n_err++;
                        $display("FAIL latency_c%0d: got tvalid=%b want %b", k, m_axis_tvalid, (k == LAT));
                    end
                    if (k < LAT) tick();
                end
                n_cmp++;
                if ({m_axis_tuser, m_axis_tdata} !== 9'h101) begin
                    n_err++;
                    $display("FAIL first_beat: got u=%b d=%h want u=1 d=01", m_axis_tuser, m_axis_tdata);
                end
            end
            for (int p = 2; p <= 8; p++) send_pix(8'(ln * 10 + p));
            repeat (4) tick();
            for (int p = 1; p <= 8; p++) exp.push_back(beat((p == 1) && (ln != 1), p == 8, 8'(ln * 10 + p)));
        end
        n_cmp++;
        if (got.size() - base != exp.size()) begin
            n_err++;
            $display("FAIL basic_count: got %0d beats want %0d", got.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (base + i >= got.size() || got[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL basic_beat%0d: got %h want %h", i, (base + i < got.size()) ? got[base + i] : 10'h3FF, exp[i]);
            end
        end
        n_cmp++;
        if ({ovf, line_err} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_flags: got ovf=%b err=%b want 0 0", ovf, line_err);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp [$];
        int base = got.size();
        m_axis_tready = 1'b0;
        pulse_sh();
        for (int p = 1; p <= 8; p++) send_pix(8'(p));
        repeat (2) tick();
        n_cmp++;
        if ({ovf, line_err, m_axis_tvalid, m_axis_tdata} !== {3'b101, 8'd1}) begin
            n_err++;
            $display("FAIL ovf_hold: got ovf=%b err=%b v=%b d=%h want 1 0 1 01", ovf, line_err, m_axis_tvalid, m_axis_tdata);
        end
        pulse_sh();
        tick();
        n_cmp++;
        if (line_err !== 1'b1 || got.size() != base) begin
            n_err++;
            $display("FAIL last_wait_sh: got err=%b beats=%0d want 1 0", line_err, got.size() - base);
        end
        m_axis_tready = 1'b1;
        repeat (8) tick();
        for (int p = 1; p <= 8; p++) send_pix(8'(p + 100));
        repeat (4) tick();
        exp = '{beat(0, 0, 8'd1), beat(0, 0, 8'd2), beat(0, 0, 8'd3), beat(0, 0, 8'd4), beat(0, 1, 8'd8)};
        n_cmp++;
        if (got.size() - base != exp.size()) begin
            n_err++;
            $display("FAIL ovf_count: got %0d beats want %0d", got.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (base + i >= got.size() || got[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL ovf_beat%0d: got %h want %h", i, (base + i < got.size()) ? got[base + i] : 10'h3FF, exp[i]);
            end
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if ({ovf, line_err} !== 2'b00) begin
            n_err++;
            $display("FAIL clr_err: got ovf=%b err=%b want 0 0", ovf, line_err);
        end
    endtask

    task automatic test_short_line();
        logic [9:0] exp [$];
        int base = got.size();
        m_axis_tready = 1'b1;
        pulse_sh();
        send_pix(8'd10);
        send_pix(8'd11);
        send_pix(8'd12);
        // clr_err lands on the same cycle the rising sh is seen inside the DUT.
        sh      = 1'b1;
        clr_err = (LAT == 1);
        tick();
        sh      = 1'b0;
        clr_err = (LAT == 2);
        tick();
        clr_err = 1'b0;
        tick();
        n_cmp++;
        if (line_err !== 1'b1) begin
            n_err++;
            $display("FAIL short_set_wins: got line_err=%b want 1", line_err);
        end
        repeat (8) tick();
        for (int p = 1; p <= 8; p++) send_pix(8'(p + 20));
        repeat (4) tick();
        exp = '{beat(1, 0, 8'd10), beat(0, 0, 8'd11), beat(0, 0, 8'd12), beat(0, 0, 8'd0),
                beat(0, 0, 8'd0), beat(0, 0, 8'd0), beat(0, 0, 8'd0), beat(0, 1, 8'd0)};
        for (int p = 1; p <= 8; p++) exp.push_back(beat(0, p == 8, 8'(p + 20)));
        n_cmp++;
        if (got.size() - base != exp.size()) begin
            n_err++;
            $display("FAIL short_count: got %0d beats want %0d", got.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (base + i >= got.size() || got[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL short_beat%0d: got %h want %h", i, (base + i < got.size()) ? got[base + i] : 10'h3FF, exp[i]);
            end
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if (line_err !== 1'b0) begin
            n_err++;
            $display("FAIL short_clear: got line_err=%b want 0", line_err);
        end
    endtask

    task automatic test_stall();
        logic [9:0] exp [$];
        logic [9:0] held;
        logic       prev_stall = 1'b0;
        int         n_stall    = 0;
        int         k          = 0;
        int         base       = got.size();
        pulse_sh();
        for (int i = 0; i < 24; i++) begin
            m_axis_tready = (i % 2 == 0);
            s_tvalid      = (i % 2 == LAT - 1) && (k < 8);
            s_tdata       = 8'(31 + k);
            if (s_tvalid) k++;
            @(negedge sys_clk);
            if (prev_stall) begin
                n_stall++;
                n_cmp++;
                if (m_axis_tvalid !== 1'b1 || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold_c%0d: got v=%b %h want v=1 %h", i, m_axis_tvalid,
                             {m_axis_tuser, m_axis_tlast, m_axis_tdata}, held);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            held       = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            tick();
        end
        s_tvalid      = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (n_stall < 4) begin
            n_err++;
            $display("FAIL stall_seen: got %0d stalled cycles want at least 4", n_stall);
        end
        for (int p = 0; p < 8; p++) exp.push_back(beat(p == 0, p == 7, 8'(31 + p)));
        n_cmp++;
        if (got.size() - base != exp.size() || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL stall_count: got %0d beats ovf=%b want %0d ovf=0", got.size() - base, ovf, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (base + i >= got.size() || got[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL stall_beat%0d: got %h want %h", i, (base + i < got.size()) ? got[base + i] : 10'h3FF, exp[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [9:0] exp [$];
        int base;
        m_axis_tready = 1'b0;
        pulse_sh();
        send_pix(8'd41);
        send_pix(8'd42);
        send_pix(8'd43);
        pulse_sh();
        tick();
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ovf, line_err} !== 13'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got v=%b d=%h l=%b u=%b ovf=%b err=%b, want all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, ovf, line_err);
        end
        repeat (2) tick();
        resetn        = 1'b1;
        m_axis_tready = 1'b1;
        base          = got.size();
        repeat (3) tick();
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || got.size() != base) begin
            n_err++;
            $display("FAIL midreset_empty: got tvalid=%b beats=%0d want 0 0", m_axis_tvalid, got.size() - base);
        end
        pulse_sh();
        for (int p = 1; p <= 8; p++) send_pix(8'(50 + p));
        repeat (4) tick();
        for (int p = 1; p <= 8; p++) exp.push_back(beat(p == 1, p == 8, 8'(50 + p)));
        n_cmp++;
        if (got.size() - base != exp.size()) begin
            n_err++;
            $display("FAIL midreset_count: got %0d beats want %0d", got.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_cmp++;
            if (base + i >= got.size() || got[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL midreset_beat%0d: got %h want %h", i, (base + i < got.size()) ? got[base + i] : 10'h3FF, exp[i]);
            end
        end
    endtask

`ifdef CCD_LINE_DARK_SUB_EN
    task automatic test_dark();
        logic [7:0] din  [8] = '{8'd5, 8'd10, 8'd11, 8'd255, 8'd20, 8'd9, 8'd0, 8'd12};
        logic [7:0] dexp [8] = '{8'd0, 8'd0, 8'd1, 8'd245, 8'd10, 8'd0, 8'd0, 8'd2};
        int base = got.size();
        dark_level    = 8'd10;
        m_axis_tready = 1'b1;
        pulse_sh();
        send_pix(din[0]);
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL dark_lat_c1: got tvalid=%b want 0", m_axis_tvalid);
        end
        tick();
        n_cmp++;
        if (m_axis_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL dark_lat_c2: got tvalid=%b want 1", m_axis_tvalid);
        end
        for (int p = 1; p < 8; p++) send_pix(din[p]);
        repeat (4) tick();
        n_cmp++;
        if (got.size() - base != 8) begin
            n_err++;
            $display("FAIL dark_count: got %0d beats want 8", got.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (base + i >= got.size() || got[base + i] !== beat(0, i == 7, dexp[i])) begin
                n_err++;
                $display("FAIL dark_beat%0d: got %h want %h", i, (base + i < got.size()) ? got[base + i] : 10'h3FF,
                         beat(0, i == 7, dexp[i]));
            end
        end
        dark_level = DARK_DEF;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_lines();
        test_overflow();
        test_short_line();
        test_stall();
        test_reset_midline();
`ifdef CCD_LINE_DARK_SUB_EN
        test_dark();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ccd_line_axis.md
CCD_LINE_AXIS -- requirements
Module: ccd_line_axis

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, which sets the pixel data width in bits.
REQ-002 The block SHALL have parameter SAMP_NUM, default 2048, which sets the number of pixels per line.
REQ-003 The block SHALL have parameter LINES_PER_FRAME, default 1024, which sets the number of lines per frame.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, which sets the output FIFO depth in entries; the value SHALL be a power of 2.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the single clock for all logic.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port sh, input, 1 bit: CCD shift-gate pulse, synchronous to sys_clk, marking a line start.
REQ-008 The block SHALL have port s_tdata, input, D_WIDTH bits: pixel from the ADC driver.
REQ-009 The block SHALL have port s_tvalid, input, 1 bit: pixel strobe; there is no ready signal, so the source never stalls.
REQ-010 The block SHALL have port dark_level, input, D_WIDTH bits: dark offset, used only when the feature in REQ-031 is compiled in.
REQ-011 The block SHALL have port clr_err, input, 1 bit: a one-cycle pulse that clears the sticky flags.
REQ-012 The block SHALL have ports m_axis_tdata (output, D_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1) and m_axis_tuser (output, 1), forming an AXI4-Stream master.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, pixel dropped because the FIFO was full.
REQ-014 The block SHALL have port line_err, output, 1 bit: sticky flag, short line or skipped line.

Function
REQ-015 The control FSM SHALL have states IDLE, ARMED, ACTIVE, PAD and LAST_WAIT.
REQ-016 IDLE SHALL go to ARMED on a rising edge of sh, detected against a registered copy of sh; s_tvalid in IDLE SHALL be ignored.
REQ-017 In ARMED, the first s_tvalid SHALL write pixel 0, set pix_cnt to 1 and go to ACTIVE.
REQ-018 In ACTIVE, each s_tvalid SHALL write one FIFO entry {tuser, tlast, data} and increment pix_cnt.
REQ-019 The entry with pix_cnt==SAMP_NUM-1 SHALL carry tlast=1, after which the FSM SHALL go to IDLE and line_cnt SHALL increment, wrapping from LINES_PER_FRAME-1 to 0.
REQ-020 tuser SHALL be 1 only on pixel 0 of a line where line_cnt==0.
REQ-021 When the FIFO is full on s_tvalid, a non-last pixel SHALL be dropped, pix_cnt SHALL still increment, and ovf SHALL be set.
REQ-022 When the FIFO is full on the last pixel, the pixel SHALL be held in a pending register and the FSM SHALL go to LAST_WAIT; the pending entry SHALL be written on the first cycle the FIFO has space, then the FSM SHALL go to IDLE, so tlast is never lost.
REQ-023 A sh rising edge in ACTIVE (short line) SHALL set line_err and go to PAD; PAD SHALL write zero-data entries, one per cycle when not full, until pix_cnt reaches SAMP_NUM, with tlast on the final entry, then go to ARMED; s_tvalid during PAD SHALL be dropped.
REQ-024 A sh rising edge in LAST_WAIT SHALL set line_err and be ignored, so the next line is skipped.
REQ-025 The FIFO SHALL be first-word fall-through; m_axis_tvalid SHALL equal not-empty; an entry SHALL pop when m_axis_tvalid && m_axis_tready; m_axis_tdata, m_axis_tlast and m_axis_tuser SHALL be held stable while m_axis_tvalid && !m_axis_tready.
REQ-026 A simultaneous push and pop on a full FIFO SHALL succeed with no drop, and full SHALL be evaluated before the pop.
REQ-027 Latency SHALL be exactly 1 cycle, from an s_tvalid accept on cycle N to m_axis_tvalid on cycle N+1, when the FIFO is empty.
REQ-028 clr_err SHALL clear ovf and line_err, except that a set event in the same cycle SHALL win.

Reset
REQ-029 While resetn=0, the FSM SHALL be IDLE, pix_cnt=0, line_cnt=0, the FIFO SHALL be empty, the pending register SHALL be cleared, all outputs SHALL be 0 and the registered sh SHALL be 0.
REQ-030 Reset asserted mid-line SHALL discard FIFO contents, and the first line after reset SHALL carry tuser=1.

Configuration
REQ-031 With macro CCD_LINE_DARK_SUB_EN defined, the pixel value written SHALL be s_tdata-dark_level, saturating to 0 when s_tdata<=dark_level; this SHALL add one register stage, making the latency 2 cycles, and PAD entries SHALL stay 0.
REQ-032 Without CCD_LINE_DARK_SUB_EN, s_tdata SHALL pass unmodified, dark_level SHALL be ignored, and the latency SHALL be 1 cycle.

Verification
REQ-033 SAMP_NUM=8, LINES_PER_FRAME=2, m_axis_tready=1, sh pulse then 8 pixels 1..8 -> the bench SHALL see 8 beats 1..8, tuser on beat 1, tlast on beat 8; on the second line, tuser=0; on the third line, tuser=1.
REQ-034 FIFO_DEPTH=4, m_axis_tready=0, 8 pixels -> the bench SHALL see the first 4 stored, ovf=1, the pixel 8 entry held in LAST_WAIT; with m_axis_tready=1, the output SHALL be 1,2,3,4,8 with tlast on 8.
REQ-035 sh, 3 pixels, then sh -> line_err=1, and the output SHALL be 3 pixels followed by 5 zeros with tlast on the 8th; the next line SHALL be captured normally.
REQ-036 With m_axis_tready toggling 1010, the bench SHALL verify no data loss or duplication, and that the outputs are stable during stalls.
REQ-037 With CCD_LINE_DARK_SUB_EN defined and dark_level=10, inputs 5, 10, 11, 255 SHALL give outputs 0, 0, 1, 245 at 2-cycle latency.
REQ-038 resetn=0 asserted mid-line, then released -> all outputs SHALL be 0 and the FIFO empty; the next line SHALL start with tuser=1, and an asserted clr_err SHALL clear the sticky flags.
